int8_quad_drain: RTL and testbench
==================================

INT8_QUAD_DRAIN -- requirements
Module: int8_quad_drain

Interface
REQ-001 SHALL have parameter wxyzOutputBits, default 32: width of each captured accumulator word and of out_data.
REQ-002 SHALL have parameter satShift, default 0: arithmetic right-shift applied before saturation; used only when INT8_QUAD_DRAIN_SAT_EN is defined.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port capture, input, 1: single-cycle pulse; w/x/y/z are final for the tile this cycle.
REQ-006 SHALL have ports w, x, y, z, input, wxyzOutputBits each: accumulator outputs of the upstream quad MAC, two's complement.
REQ-007 SHALL have port out_ready, input, 1: downstream accepts out_data this cycle.
REQ-008 SHALL have port out_valid, output, 1: out_data and out_idx hold a valid word.
REQ-009 SHALL have port out_data, output, wxyzOutputBits: drained word.
REQ-010 SHALL have port out_idx, output, 2: word index, 0=w, 1=x, 2=y, 3=z.
REQ-011 SHALL have port busy, output, 1: high while in state SEND.
REQ-012 SHALL have port overrun, output, 1: one-cycle pulse when a capture is dropped.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and SEND; busy = (state==SEND); out_valid = busy.
REQ-014 In IDLE, capture high SHALL latch w,x,y,z into a 4-entry buffer, set index to 0, and enter SEND at the next edge.
REQ-015 First word latency SHALL be one cycle: capture at cycle N gives out_valid=1, out_idx=0 and out_data=w at cycle N+1.
REQ-016 out_data SHALL equal buffer[index] and SHALL be driven from registers only, with no combinational path from w/x/y/z/capture.
REQ-017 Handshake: a word transfers on an edge where out_valid and out_ready are both high; index then increments by 1.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_idx SHALL hold stable.
REQ-019 The transfer at index 3 SHALL return the FSM to IDLE and wrap index to 0, unless REQ-020 applies.
REQ-020 capture in the same cycle as the index-3 transfer SHALL latch the new words, set index to 0, and stay in SEND, so there is no bubble between tiles.
REQ-021 capture in SEND in any other cycle SHALL be ignored: the buffer is unchanged and overrun pulses high for exactly the next cycle.
REQ-022 out_ready SHALL be ignored in IDLE.
REQ-023 A batch SHALL take at least 4 cycles; with out_ready held high it SHALL take exactly 4 cycles.

Reset
REQ-024 On rst assertion, the block SHALL immediately enter IDLE, with index=0, buffer=0, out_valid=0, out_data=0, out_idx=0, busy=0 and overrun=0.
REQ-025 Reset during SEND SHALL discard the remaining words; no partial batch resumes after reset.
REQ-026 capture during reset SHALL be ignored; the first capture accepted is the first one at a rising edge after rst deasserts.

Configuration
REQ-027 SHALL support macro INT8_QUAD_DRAIN_SAT_EN.
REQ-028 With INT8_QUAD_DRAIN_SAT_EN defined, each word SHALL be arithmetic-shifted right by satShift, saturated to the signed range [-128,127], and sign-extended to wxyzOutputBits, all at capture time into the buffer.
REQ-029 Without the macro, the raw words SHALL be stored and output unchanged, and satShift SHALL have no effect.

Verification
REQ-030 Basic drain: w=1,x=2,y=3,z=4, capture, out_ready=1 -> values 1,2,3,4 with idx 0..3 on cycles N+1..N+4, then busy=0.
REQ-031 Backpressure: out_ready low for 3 cycles at idx=1 -> out_data=2 and idx=1 held stable, then drain completes; total 7 valid cycles.
REQ-032 Back-to-back: second capture coincident with the idx-3 transfer -> the new w appears at idx 0 in the next cycle, with no out_valid gap and overrun=0.
REQ-033 Overrun: capture at idx=1 -> overrun high for one cycle and the original words still drain unchanged.
REQ-034 Reset: rst asserted at idx=2 -> all outputs 0 immediately; after release, a new capture drains from idx 0.
REQ-035 SAT_EN, satShift=4: w=0x00001000 -> 127; x=0xFFFFF000 -> -128 (0xFFFFFF80); y=0x00000050 -> 5; z=0xFFFFFFF0 -> -1.

Source files
------------

// File: rtl/int8_quad_drain.sv
// int8_quad_drain: drains four captured accumulator words (w,x,y,z) one per handshake.
// Build option INT8_QUAD_DRAIN_SAT_EN: shift each word right by satShift and saturate it to int8 at capture.
module int8_quad_drain #(
   parameter int wxyzOutputBits = 32,
   parameter int satShift = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      capture,
   input  logic [wxyzOutputBits-1:0] w,
   input  logic [wxyzOutputBits-1:0] x,
   input  logic [wxyzOutputBits-1:0] y,
   input  logic [wxyzOutputBits-1:0] z,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [wxyzOutputBits-1:0] out_data,
   output logic [1:0]                out_idx,
   output logic                      busy,
   output logic                      overrun
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t                    state_q, state_d;
   logic [1:0]                idx_q, idx_d;
   logic                      ovr_q, ovr_d;
   logic [wxyzOutputBits-1:0] buf_q [4];
   logic [wxyzOutputBits-1:0] buf_d [4];
   logic                      fire, last, load;
`ifdef INT8_QUAD_DRAIN_SAT_EN
   localparam logic signed [wxyzOutputBits-1:0] SAT_MAX = 127;
   localparam logic signed [wxyzOutputBits-1:0] SAT_MIN = -128;
   function automatic logic [wxyzOutputBits-1:0] conv(input logic [wxyzOutputBits-1:0] v);
      logic signed [wxyzOutputBits-1:0] s;
      s = $signed(v) >>> satShift;
      conv = s > SAT_MAX ? SAT_MAX : s < SAT_MIN ? SAT_MIN : s;
   endfunction
`else
   logic unused_sat;
   assign unused_sat = |satShift;
   function automatic logic [wxyzOutputBits-1:0] conv(input logic [wxyzOutputBits-1:0] v);
      conv = v;
   endfunction
`endif
   // state register: FSM state, word index, overrun flag and the word buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         ovr_q   <= 1'b0;
         for (int i = 0; i < 4; i++) buf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ovr_q   <= ovr_d;
         for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
      end
   end
   // next state: a capture loads when idle or on the final transfer, otherwise it is dropped
   always_comb begin
      fire     = state_q == SEND && out_ready;
      last     = fire && idx_q == 2'd3;
      load     = capture && (state_q == IDLE || last);
      state_d  = load ? SEND : last ? IDLE : state_q;
      idx_d    = load ? 2'd0 : fire ? idx_q + 2'd1 : idx_q;
      ovr_d    = capture && state_q == SEND && !last;
      buf_d[0] = load ? conv(w) : buf_q[0];
      buf_d[1] = load ? conv(x) : buf_q[1];
      buf_d[2] = load ? conv(y) : buf_q[2];
      buf_d[3] = load ? conv(z) : buf_q[3];
   end
   // outputs: decoded purely from registered state
   always_comb begin
      busy      = state_q == SEND;
      out_valid = busy;
      out_data  = buf_q[idx_q];
      out_idx   = idx_q;
      overrun   = ovr_q;
   end
endmodule

// File: tb/tb_int8_quad_drain.sv
// tb_int8_quad_drain: directed and random stimulus against a queue-based reference model.
module tb_int8_quad_drain;
   localparam int SH = 4;
   logic        clk = 1'b0;
   logic        rst, capture, out_ready;
   logic [31:0] w, x, y, z;
   logic        out_valid, busy, overrun;
   logic [31:0] out_data;
   logic [1:0]  out_idx;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] q[$];
   logic        exp_ovr = 1'b0;

   int8_quad_drain #(.wxyzOutputBits(32), .satShift(SH)) dut (
      .clk(clk), .rst(rst), .capture(capture),
      .w(w), .x(x), .y(y), .z(z),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_idx(out_idx), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] conv(input logic [31:0] v);
`ifdef INT8_QUAD_DRAIN_SAT_EN
      longint s;
      s = longint'($signed(v)) >>> SH;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return 32'(s);
`else
      return v;
`endif
   endfunction

   task automatic check_outputs();
      chk("valid", 32'(out_valid), 32'(q.size() != 0));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      if (q.size() != 0) begin
         chk("data", out_data, q[0]);
         chk("idx", 32'(out_idx), 32'(4 - q.size()));
      end
   endtask

   task automatic step(input logic cap, input logic rdy, input logic [31:0] a, b, c, d);
      logic was_idle, xfer;
      check_outputs();
      capture = cap; out_ready = rdy; w = a; x = b; y = c; z = d;
      was_idle = q.size() == 0;
      xfer = !was_idle && rdy;
      if (xfer) void'(q.pop_front());
      exp_ovr = 1'b0;
      if (cap) begin
         if (was_idle || (xfer && q.size() == 0)) begin
            q.push_back(conv(a)); q.push_back(conv(b));
            q.push_back(conv(c)); q.push_back(conv(d));
         end else exp_ovr = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; capture = 1'b1;
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_data", out_data, 0);
      chk("rst_idx", 32'(out_idx), 0);
      q.delete();
      exp_ovr = 1'b0;
      @(negedge clk);
      rst = 1'b0; capture = 1'b0;
   endtask

   initial begin
      rst = 1'b1; capture = 1'b0; out_ready = 1'b0;
      w = '0; x = '0; y = '0; z = '0;
      repeat (2) @(negedge clk);
      do_reset();
      // basic drain then idle
      step(1, 1, 1, 2, 3, 4);
      repeat (5) step(0, 1, 0, 0, 0, 0);
      // backpressure at idx 1; ready is ignored while idle
      step(1, 0, 10, 20, 30, 40);
      step(0, 1, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0);
      repeat (4) step(0, 1, 0, 0, 0, 0);
      // back-to-back tiles with capture on the idx-3 transfer
      step(1, 1, 5, 6, 7, 8);
      repeat (3) step(0, 1, 0, 0, 0, 0);
      step(1, 1, 9, 10, 11, 12);
      repeat (5) step(0, 1, 0, 0, 0, 0);
      // overrun at idx 1
      step(1, 1, 21, 22, 23, 24);
      step(0, 1, 0, 0, 0, 0);
      step(1, 1, 99, 98, 97, 96);
      repeat (4) step(0, 1, 0, 0, 0, 0);
      // reset at idx 2, then a fresh tile
      step(1, 1, 31, 32, 33, 34);
      repeat (2) step(0, 1, 0, 0, 0, 0);
      do_reset();
      step(1, 1, 41, 42, 43, 44);
      repeat (5) step(0, 1, 0, 0, 0, 0);
      // saturation corner values (raw when saturation is not built in)
      step(1, 1, 32'h0000_1000, 32'hFFFF_F000, 32'h0000_0050, 32'hFFFF_FFF0);
      repeat (5) step(0, 1, 0, 0, 0, 0);
      // random traffic with a mid-run reset
      for (int i = 0; i < 800; i++) begin
         if (i == 400) do_reset();
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
              $urandom, $urandom, $urandom, $urandom);
      end
      check_outputs();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
